// File: rtl/fpnew_pkg.sv
// fpnew_pkg: shared FPU types and limits used by the slice result buffer
package fpnew_pkg;

    typedef struct packed {
        logic NV;
        logic DZ;
        logic OF;
        logic UF;
        logic NX;
    } status_t;

    localparam int unsigned FPNEW_SLICE_BUF_MAX_DEPTH = 16;

endpackage

// File: rtl/fpnew_sticky_flags.sv
// fpnew_sticky_flags: sticky status accumulator, clear applied before the new flags are ORed in
module fpnew_sticky_flags
    import fpnew_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    clr_i,
    input  logic    set_i,
    input  status_t flags_i,
    output status_t flags_o
);

    logic [$bits(status_t)-1:0] flags_q;

    // clear first, then accumulate the flags that arrive in the same cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            flags_q <= '0;
        else if (clr_i || set_i)
            flags_q <= (clr_i ? '0 : flags_q) | (set_i ? flags_i : '0);
    end

    assign flags_o = status_t'(flags_q);

endmodule

// File: rtl/fpnew_slice_result_buffer.sv
// fpnew_slice_result_buffer: in-order FWFT result FIFO between a format slice and the opgroup arbiter (sticky flags under FPNEW_SLICE_STICKY_FLAGS_EN)
module fpnew_slice_result_buffer
    import fpnew_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned Depth   = 2,
    parameter type         TagType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [Width-1:0]           result_i,
    input  status_t                    status_i,
    input  logic                       extension_bit_i,
    input  TagType                     tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [Width-1:0]           result_o,
    output status_t                    status_o,
    output logic                       extension_bit_o,
    output TagType                     tag_o,
`ifdef FPNEW_SLICE_STICKY_FLAGS_EN
    output status_t                    fflags_o,
    input  logic                       fflags_clr_i,
`endif
    output logic [$clog2(Depth+1)-1:0] usage_o,
    output logic                       busy_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    if (Depth < 1 || Depth > FPNEW_SLICE_BUF_MAX_DEPTH) begin : g_bad_depth
        $error("fpnew_slice_result_buffer: Depth out of range");
    end

    typedef struct packed {
        logic [Width-1:0] result;
        status_t          status;
        logic             ext;
        TagType           tag;
    } entry_t;

    entry_t            mem_q [Depth];
    entry_t            head;
    logic [PtrW-1:0]   wr_q, rd_q;
    logic [CntW-1:0]   cnt_q;
    logic              push, pop;

    assign in_ready_o  = cnt_q < CntW'(Depth);
    assign out_valid_o = cnt_q != '0;
    assign busy_o      = out_valid_o;
    assign usage_o     = cnt_q;
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;
    assign head        = mem_q[rd_q];

    function automatic logic [PtrW-1:0] inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    // pointer and occupancy bookkeeping; flush overrides any same-cycle push or pop
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= inc(wr_q);
            if (pop) rd_q <= inc(rd_q);
            cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
        end
    end

    // entry storage needs no reset: it is only visible while count is non-zero
    always_ff @(posedge clk_i) begin
        if (push && !flush_i)
            mem_q[wr_q] <= '{result: result_i, status: status_i, ext: extension_bit_i, tag: tag_i};
    end

    // head entry, forced to zero while empty
    always_comb begin
        result_o        = out_valid_o ? head.result : '0;
        status_o        = out_valid_o ? head.status : '0;
        extension_bit_o = out_valid_o ? head.ext : 1'b0;
        tag_o           = out_valid_o ? head.tag : '0;
    end

`ifdef FPNEW_SLICE_STICKY_FLAGS_EN
    fpnew_sticky_flags u_sticky (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (fflags_clr_i),
        .set_i   (pop && !flush_i),
        .flags_i (status_o),
        .flags_o (fflags_o)
    );
`endif

endmodule

// File: doc/fpnew_slice_result_buffer.md
# fpnew_slice_result_buffer

Result buffer placed directly downstream of an opgroup format slice. It captures each completed slice result together with its status flags, extension bit and tag into a small first-word-fall-through FIFO. Results are released in order to the opgroup output arbiter. The buffer decouples the slice's pipeline from arbiter back-pressure, so the slice can keep retiring operations while the arbiter serves other formats.

## Interface
Parameters:
- Width, 32, result width; matches the slice's Width.
- Depth, 2, number of entries; legal range 1..16.
- TagType, logic, type of the tag carried with each result.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- flush_i  in  1  discard all stored entries.
- in_valid_i  in  1  slice result valid.
- in_ready_o  out  1  buffer can accept a result.
- result_i  in  Width  slice result.
- status_i  in  fpnew_pkg::status_t (5)  slice status flags.
- extension_bit_i  in  1  slice extension bit.
- tag_i  in  TagType  slice tag.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  arbiter accepts head entry.
- result_o  out  Width  head result.
- status_o  out  status_t  head status.
- extension_bit_o  out  1  head extension bit.
- tag_o  out  TagType  head tag.
- usage_o  out  $clog2(Depth+1)  number of stored entries.
- busy_o  out  1  at least one entry stored.
- fflags_o  out  status_t  sticky flags; present only with the macro below.
- fflags_clr_i  in  1  clear sticky flags; present only with the macro below.

## Operation
- Storage: Depth entries of {result, status, ext bit, tag}, plus write pointer, read pointer and count.
- Pointers wrap from Depth-1 to 0; Depth is not required to be a power of two.
- Push: in_valid_i & in_ready_o. The entry is written at the write pointer and the write pointer advances.
- Pop: out_valid_o & out_ready_i. The read pointer advances.
- in_ready_o = (count < Depth). It depends only on registered state, so there is no combinational path from out_ready_i.
- out_valid_o = busy_o = (count != 0). usage_o = count.
- Head outputs show the entry at the read pointer. While empty, result_o, status_o, extension_bit_o and tag_o are '0.
- Push and pop in the same cycle: count is unchanged and both pointers advance. This is legal at any fill level below Depth. When full, only a pop occurs.
- flush_i: at the next edge, count and both pointers go to 0. A push or pop in the same cycle is ignored, so flush wins.
- Once out_valid_o is high, the head entry stays stable until it is popped or flushed.

## Timing
- Latency: a result pushed at edge N is visible on the outputs after edge N. This is a minimum of 1 cycle from in_valid_i to out_valid_o; there is no combinational bypass.
- Sustained throughput is 1 result per cycle when Depth ≥ 2 and out_ready_i stays high.
- With Depth = 1, throughput is 1 result every 2 cycles.
- Reset values: count = 0, pointers = 0, out_valid_o = 0, busy_o = 0, usage_o = 0, in_ready_o = 1, head outputs = '0, fflags_o = '0.
- If reset is asserted mid-operation, all entries are lost immediately (asynchronous reset).

## Configuration
- Macro: FPNEW_SLICE_STICKY_FLAGS_EN.
- With the macro defined:
  - fflags_o / fflags_clr_i exist.
  - On each pop, status_o is ORed into fflags.
  - fflags_clr_i clears fflags at the next edge.
  - Clear and pop in the same cycle: fflags = popped status (clear first, then accumulate).
  - flush_i does not affect fflags.
- Without the macro: neither port nor register exists, and the buffer is a pure FIFO.

## Structure
- status_t comes from fpnew_pkg.
- Add a constant FPNEW_SLICE_BUF_MAX_DEPTH = 16 to fpnew_pkg. An elaboration assertion checks 1 ≤ Depth ≤ MAX.
- One sub-module, fpnew_sticky_flags: the accumulator register with set/clear. It is instantiated only under the macro.
- FIFO control and storage stay in the top module.

## Test plan
- Reset check: assert rst_i mid-stream with 2 entries stored → immediately out_valid_o = 0, usage_o = 0, in_ready_o = 1, result_o = 0.
- Fill and drain: Depth = 2, out_ready_i = 0, push 0xA, then 0xB.
  - After 2 pushes: in_ready_o = 0, usage_o = 2.
  - Raise out_ready_i: pops 0xA then 0xB in order, with tags preserved.
- Streaming: Depth = 2, out_ready_i = 1, push 100 results on consecutive cycles → 100 pops on consecutive cycles, each 1 cycle after its push, values in order, usage_o ≤ 1.
- Wrap-around: Depth = 3, push/pop pattern that moves the pointers through index 2 → 0 six times → no loss or duplication of 20 tagged results.
- Flush precedence: 1 entry stored, and in the same cycle flush_i = 1, in_valid_i = 1, out_ready_i = 1 → next cycle usage_o = 0, out_valid_o = 0, and the pushed result never appears.
- Sticky flags (macro on):
  - Pop status 5'b00001, then 5'b10000 → fflags_o = 5'b10001.
  - fflags_clr_i together with a pop of 5'b00100 → fflags_o = 5'b00100.
  - A following flush leaves fflags_o = 5'b00100.
